// File: rtl/axi_arbiter_2x1.sv
// rtl/axi_arbiter_2x1.sv - two-master AXI arbiter with independent read/write grant FSMs
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed m1 priority.
package axi_arbiter_2x1_pkg;
  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [2:0]  arprot;
    logic        rready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [2:0]  awprot;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } axi_req_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
  } axi_resp_t;
endpackage

module axi_arbiter_2x1
  import axi_arbiter_2x1_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  axi_req_t  ibus_req,
  output axi_resp_t ibus_resp,
  input  axi_req_t  dbus_req,
  output axi_resp_t dbus_resp,
  output axi_req_t  axi_req,
  input  axi_resp_t axi_resp,
  output logic [1:0] rd_owner,
  output logic [1:0] wr_owner
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t   rd_state, rd_state_nxt, wr_state, wr_state_nxt;
  logic     rd_own, rd_own_nxt, wr_own, wr_own_nxt;
  logic     rd_win, wr_win;
  logic     rd_busy, wr_busy;
  axi_req_t rd_src, wr_src;
  axi_resp_t rd_part, wr_part;

`ifdef ARB_ROUND_ROBIN_EN
  logic rd_last, rd_last_nxt, wr_last, wr_last_nxt;

  // On conflict the master that did not win last time gets the channel.
  assign rd_win = (ibus_req.arvalid && dbus_req.arvalid) ? ~rd_last : dbus_req.arvalid;
  assign wr_win = (ibus_req.awvalid && dbus_req.awvalid) ? ~wr_last : dbus_req.awvalid;
`else
  assign rd_win = dbus_req.arvalid;
  assign wr_win = dbus_req.awvalid;
`endif

  assign rd_busy  = (rd_state == BUSY);
  assign wr_busy  = (wr_state == BUSY);
  assign rd_src   = rd_own ? dbus_req : ibus_req;
  assign wr_src   = wr_own ? dbus_req : ibus_req;
  assign rd_owner = {rd_busy, rd_busy & rd_own};
  assign wr_owner = {wr_busy, wr_busy & wr_own};

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= IDLE;
      wr_state <= IDLE;
      rd_own   <= 1'b0;
      wr_own   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rd_last  <= 1'b1;
      wr_last  <= 1'b1;
`endif
    end else begin
      rd_state <= rd_state_nxt;
      wr_state <= wr_state_nxt;
      rd_own   <= rd_own_nxt;
      wr_own   <= wr_own_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      rd_last  <= rd_last_nxt;
      wr_last  <= wr_last_nxt;
`endif
    end
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_own_nxt   = rd_own;
`ifdef ARB_ROUND_ROBIN_EN
    rd_last_nxt  = rd_last;
`endif
    case (rd_state)
      IDLE: begin
        if (ibus_req.arvalid || dbus_req.arvalid) begin
          rd_state_nxt = BUSY;
          rd_own_nxt   = rd_win;
`ifdef ARB_ROUND_ROBIN_EN
          rd_last_nxt  = rd_win;
`endif
        end
      end
      BUSY: begin
        // Burst ends on the last R beat; re-arbitration waits for the IDLE cycle.
        if (axi_resp.rvalid && rd_src.rready && axi_resp.rlast) rd_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_state_nxt = wr_state;
    wr_own_nxt   = wr_own;
`ifdef ARB_ROUND_ROBIN_EN
    wr_last_nxt  = wr_last;
`endif
    case (wr_state)
      IDLE: begin
        if (ibus_req.awvalid || dbus_req.awvalid) begin
          wr_state_nxt = BUSY;
          wr_own_nxt   = wr_win;
`ifdef ARB_ROUND_ROBIN_EN
          wr_last_nxt  = wr_win;
`endif
        end
      end
      BUSY: begin
        if (axi_resp.bvalid && wr_src.bready) wr_state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    axi_req = '0;
    if (rd_busy) begin
      axi_req.arvalid = rd_src.arvalid;
      axi_req.araddr  = rd_src.araddr;
      axi_req.arlen   = rd_src.arlen;
      axi_req.arsize  = rd_src.arsize;
      axi_req.arburst = rd_src.arburst;
      axi_req.arlock  = rd_src.arlock;
      axi_req.arprot  = rd_src.arprot;
      axi_req.rready  = rd_src.rready;
    end
    if (wr_busy) begin
      axi_req.awvalid = wr_src.awvalid;
      axi_req.awaddr  = wr_src.awaddr;
      axi_req.awlen   = wr_src.awlen;
      axi_req.awsize  = wr_src.awsize;
      axi_req.awburst = wr_src.awburst;
      axi_req.awlock  = wr_src.awlock;
      axi_req.awprot  = wr_src.awprot;
      axi_req.wvalid  = wr_src.wvalid;
      axi_req.wdata   = wr_src.wdata;
      axi_req.wstrb   = wr_src.wstrb;
      axi_req.wlast   = wr_src.wlast;
      axi_req.bready  = wr_src.bready;
    end
  end

  // Each channel's slice of the slave response; only the owner sees it.
  always_comb begin
    rd_part = '0;
    wr_part = '0;
    if (rd_busy) begin
      rd_part.arready = axi_resp.arready;
      rd_part.rvalid  = axi_resp.rvalid;
      rd_part.rdata   = axi_resp.rdata;
      rd_part.rresp   = axi_resp.rresp;
      rd_part.rlast   = axi_resp.rlast;
    end
    if (wr_busy) begin
      wr_part.awready = axi_resp.awready;
      wr_part.wready  = axi_resp.wready;
      wr_part.bvalid  = axi_resp.bvalid;
      wr_part.bresp   = axi_resp.bresp;
    end
  end

  assign ibus_resp = (rd_own ? axi_resp_t'('0) : rd_part) | (wr_own ? axi_resp_t'('0) : wr_part);
  assign dbus_resp = (rd_own ? rd_part : axi_resp_t'('0)) | (wr_own ? wr_part : axi_resp_t'('0));

endmodule

// File: tb/tb_axi_arbiter_2x1.sv
// tb/tb_axi_arbiter_2x1.sv - self-checking bench for axi_arbiter_2x1
module tb_axi_arbiter_2x1;
  import axi_arbiter_2x1_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  axi_req_t  ibus_req, dbus_req, axi_req;
  axi_resp_t ibus_resp, dbus_resp, axi_resp, tbl_resp, model_resp;
  logic [1:0] rd_owner, wr_owner;
  logic      use_model;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign axi_resp = use_model ? model_resp : tbl_resp;

  axi_arbiter_2x1 dut (
    .clk       (clk),
    .rst       (rst),
    .ibus_req  (ibus_req),
    .ibus_resp (ibus_resp),
    .dbus_req  (dbus_req),
    .dbus_resp (dbus_resp),
    .axi_req   (axi_req),
    .axi_resp  (axi_resp),
    .rd_owner  (rd_owner),
    .wr_owner  (wr_owner)
  );

  // Simple downstream slave: one read burst and one write at a time.
  logic [8:0] s_rd_left;
  logic       s_aw_got, s_w_got, s_bvalid;

  always_comb begin
    model_resp         = '0;
    model_resp.arready = (s_rd_left == 9'd0);
    model_resp.rvalid  = (s_rd_left != 9'd0);
    model_resp.rlast   = (s_rd_left == 9'd1);
    model_resp.rdata   = 32'hA000_0000 | {23'h0, s_rd_left};
    model_resp.awready = !s_aw_got && !s_bvalid;
    model_resp.wready  = !s_w_got && !s_bvalid;
    model_resp.bvalid  = s_bvalid;
  end

  always @(posedge clk) begin
    if (rst) begin
      s_rd_left <= 9'd0;
      s_aw_got  <= 1'b0;
      s_w_got   <= 1'b0;
      s_bvalid  <= 1'b0;
    end else begin
      if (axi_req.arvalid && model_resp.arready) s_rd_left <= {1'b0, axi_req.arlen} + 9'd1;
      else if (model_resp.rvalid && axi_req.rready) s_rd_left <= s_rd_left - 9'd1;
      if (s_bvalid) begin
        if (axi_req.bready) s_bvalid <= 1'b0;
      end else if (s_aw_got && s_w_got) begin
        s_bvalid <= 1'b1;
        s_aw_got <= 1'b0;
        s_w_got  <= 1'b0;
      end else begin
        if (axi_req.awvalid && model_resp.awready) s_aw_got <= 1'b1;
        if (axi_req.wvalid && model_resp.wready && axi_req.wlast) s_w_got <= 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    ibus_req = '0;
    dbus_req = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // {iav, dav, sar, srv, srl, irr, drr} then {rd_owner, iar, dar, irv, drv, dn_arvalid, dn_rready}
  typedef struct packed {
    logic       iav, dav, sar, srv, srl, irr, drr;
    logic [7:0] exp;
  } vec_t;

  vec_t vt [13];
  int   ib, dr, db, ibv, k;
  logic ar_hs, aw_hs, w_hs, got_last, done_b, hit;

  initial begin
    vt[0]  = {7'b1100011, 8'b00000000};
`ifdef ARB_ROUND_ROBIN_EN
    vt[1]  = {7'b1110011, 8'b10100011};
    vt[2]  = {7'b1101111, 8'b10001011};
`else
    vt[1]  = {7'b1110011, 8'b11010011};
    vt[2]  = {7'b1101111, 8'b11000111};
`endif
    vt[3]  = {7'b1100011, 8'b00000000};
    vt[4]  = {7'b1110011, 8'b11010011};
    vt[5]  = {7'b1001111, 8'b11000101};
    vt[6]  = {7'b1010011, 8'b00000000};
    vt[7]  = {7'b1010011, 8'b10100011};
    vt[8]  = {7'b0001011, 8'b10001001};
    vt[9]  = {7'b0001011, 8'b10001001};
    vt[10] = {7'b0001011, 8'b10001001};
    vt[11] = {7'b0001111, 8'b10001001};
    vt[12] = {7'b0011111, 8'b00000000};

    tbl_resp  = '0;
    use_model = 1'b0;
    do_reset();
    @(negedge clk);
    chk("reset_rd_owner", 64'(rd_owner), 64'(0));
    chk("reset_wr_owner", 64'(wr_owner), 64'(0));
    chk("reset_ibus_resp", 64'(ibus_resp), 64'(0));
    chk("reset_dbus_resp", 64'(dbus_resp), 64'(0));

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ibus_req.arvalid = vt[i].iav;
      dbus_req.arvalid = vt[i].dav;
      ibus_req.rready  = vt[i].irr;
      dbus_req.rready  = vt[i].drr;
      tbl_resp.arready = vt[i].sar;
      tbl_resp.rvalid  = vt[i].srv;
      tbl_resp.rlast   = vt[i].srl;
      #1;
      chk($sformatf("vec%0d", i),
          64'({rd_owner, ibus_resp.arready, dbus_resp.arready, ibus_resp.rvalid,
               dbus_resp.rvalid, axi_req.arvalid, axi_req.rready}),
          64'(vt[i].exp));
    end

    // m0 read burst concurrent with m1 single write
    use_model = 1'b1;
    do_reset();
    @(negedge clk);
    ibus_req.arvalid = 1'b1;
    ibus_req.araddr  = 32'h1FC0_0000;
    ibus_req.arlen   = 8'd3;
    ibus_req.rready  = 1'b1;
    dbus_req.awvalid = 1'b1;
    dbus_req.awaddr  = 32'h8000_1000;
    dbus_req.wvalid  = 1'b1;
    dbus_req.wdata   = 32'hDEAD_BEEF;
    dbus_req.wstrb   = 4'hF;
    dbus_req.wlast   = 1'b1;
    dbus_req.bready  = 1'b1;
    ib = 0; dr = 0; db = 0; ibv = 0;
    for (int c = 0; c < 40 && !(ib == 4 && db == 1); c++) begin
      @(negedge clk);
      #1;
      if (rd_owner == 2'b10 && axi_req.arvalid) chk("A_araddr", 64'(axi_req.araddr), 64'h1FC0_0000);
      if (wr_owner == 2'b11 && axi_req.awvalid) chk("A_awaddr", 64'(axi_req.awaddr), 64'h8000_1000);
      if (wr_owner == 2'b11 && axi_req.wvalid) begin
        chk("A_wdata", 64'(axi_req.wdata), 64'hDEAD_BEEF);
        chk("A_wstrb", 64'(axi_req.wstrb), 64'hF);
      end
      if (ibus_resp.rvalid) ib++;
      if (dbus_resp.rvalid) dr++;
      if (ibus_resp.bvalid) ibv++;
      if (dbus_resp.bvalid && dbus_req.bready) db++;
      ar_hs = ibus_req.arvalid && ibus_resp.arready;
      aw_hs = dbus_req.awvalid && dbus_resp.awready;
      w_hs  = dbus_req.wvalid && dbus_resp.wready;
      @(posedge clk);
      #1;
      if (ar_hs) ibus_req.arvalid = 1'b0;
      if (aw_hs) dbus_req.awvalid = 1'b0;
      if (w_hs)  dbus_req.wvalid  = 1'b0;
    end
    chk("A_m0_beats", 64'(ib), 64'(4));
    chk("A_m1_rvalid", 64'(dr), 64'(0));
    chk("A_m1_bvalid", 64'(db), 64'(1));
    chk("A_m0_bvalid", 64'(ibv), 64'(0));
    @(negedge clk);
    chk("A_rd_idle", 64'(rd_owner), 64'(0));
    chk("A_wr_idle", 64'(wr_owner), 64'(0));

    // m1 requests during beat 2 of an m0 burst
    do_reset();
    @(negedge clk);
    ibus_req.arvalid = 1'b1;
    ibus_req.araddr  = 32'h1FC0_0000;
    ibus_req.arlen   = 8'd3;
    ibus_req.rready  = 1'b1;
    dbus_req.araddr  = 32'h0000_2000;
    dbus_req.rready  = 1'b1;
    got_last = 1'b0; done_b = 1'b0; k = 0; ib = 0;
    for (int c = 0; c < 40 && !done_b; c++) begin
      @(negedge clk);
      #1;
      if (!got_last) begin
        if (dbus_req.arvalid) chk("B_m1_arready_blocked", 64'(dbus_resp.arready), 64'(0));
      end else begin
        k++;
        if (k == 1) begin
          chk("B_gap_owner", 64'(rd_owner), 64'(0));
          chk("B_gap_arready", 64'(dbus_resp.arready), 64'(0));
        end else begin
          chk("B_m1_owner", 64'(rd_owner), 64'(3));
          chk("B_m1_arready", 64'(dbus_resp.arready), 64'(1));
          done_b = 1'b1;
        end
      end
      if (ibus_resp.rvalid && ibus_req.rready) begin
        ib++;
        if (ibus_resp.rlast) got_last = 1'b1;
      end
      ar_hs = ibus_req.arvalid && ibus_resp.arready;
      @(posedge clk);
      #1;
      if (ar_hs) ibus_req.arvalid = 1'b0;
      if (ib == 1) dbus_req.arvalid = 1'b1;
    end
    chk("B_done", 64'(done_b), 64'(1));
    chk("B_m0_beats", 64'(ib), 64'(4));

    // reset during beat 2 of an m1 burst, then a fresh m0 read
    do_reset();
    @(negedge clk);
    dbus_req.arvalid = 1'b1;
    dbus_req.araddr  = 32'h0000_3000;
    dbus_req.arlen   = 8'd3;
    dbus_req.rready  = 1'b1;
    ibus_req.rready  = 1'b1;
    db = 0; hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (dbus_resp.rvalid && dbus_req.rready) db++;
      ar_hs = dbus_req.arvalid && dbus_resp.arready;
      @(posedge clk);
      #1;
      if (ar_hs) dbus_req.arvalid = 1'b0;
      if (db == 1) begin
        rst = 1'b1;
        hit = 1'b1;
      end
    end
    chk("C_reset_hit", 64'(hit), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    dbus_req = '0;
    @(negedge clk);
    chk("C_rd_owner", 64'(rd_owner), 64'(0));
    chk("C_wr_owner", 64'(wr_owner), 64'(0));
    chk("C_ibus_resp", 64'(ibus_resp), 64'(0));
    chk("C_dbus_resp", 64'(dbus_resp), 64'(0));
    chk("C_axi_req_zero", 64'(axi_req == '0), 64'(1));

    ibus_req.arvalid = 1'b1;
    ibus_req.araddr  = 32'h1FC0_0000;
    ibus_req.arlen   = 8'd3;
    ib = 0; dr = 0;
    for (int c = 0; c < 40 && ib < 4; c++) begin
      @(negedge clk);
      #1;
      if (ibus_resp.rvalid && ibus_req.rready) ib++;
      if (dbus_resp.rvalid) dr++;
      ar_hs = ibus_req.arvalid && ibus_resp.arready;
      @(posedge clk);
      #1;
      if (ar_hs) ibus_req.arvalid = 1'b0;
    end
    chk("C_m0_beats", 64'(ib), 64'(4));
    chk("C_m1_rvalid", 64'(dr), 64'(0));
    @(negedge clk);
    chk("C_rd_idle", 64'(rd_owner), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_arbiter_2x1.md
AXI_ARBITER_2X1 -- requirements
Module: axi_arbiter_2x1

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port ibus_req, input, axi_req_t (140 bits): AXI request from the instruction-side master (m0).
REQ-004 SHALL have port ibus_resp, output, axi_resp_t (42 bits): AXI response to m0.
REQ-005 SHALL have port dbus_req, input, axi_req_t (140 bits): AXI request from the data-side master (m1).
REQ-006 SHALL have port dbus_resp, output, axi_resp_t (42 bits): AXI response to m1.
REQ-007 SHALL have port axi_req, output, axi_req_t (140 bits): request to the shared downstream AXI slave.
REQ-008 SHALL have port axi_resp, input, axi_resp_t (42 bits): response from the shared slave.
REQ-009 SHALL have port rd_owner, output, 2 bits: {valid, id}, where id 0=m0 and 1=m1; current read-channel grant.
REQ-010 SHALL have port wr_owner, output, 2 bits: {valid, id}; current write-channel grant.

Function
REQ-011 SHALL run two independent FSMs: a read FSM (AR+R) and a write FSM (AW+W+B); each has states IDLE and BUSY plus a 1-bit owner register.
REQ-012 Read FSM in IDLE with any arvalid=1: next cycle SHALL go to BUSY with owner=winner. The one-cycle grant latency is fixed, with no combinational pass-through in IDLE.
REQ-013 Write FSM in IDLE with any awvalid=1: next cycle SHALL go to BUSY with owner=winner.
REQ-014 Read BUSY: all ar* signals and rready SHALL be muxed from the owner to axi_req. arready, rdata, rresp, rlast and rvalid SHALL be muxed to the owner's resp.
REQ-015 Read BUSY SHALL return to IDLE the cycle after an R handshake with rlast=1 (rvalid&rready&rlast). The FSM SHALL NOT re-grant in that same cycle.
REQ-016 Write BUSY: aw*, w* and bready SHALL be muxed from the owner, and awready, wready, bresp and bvalid to the owner. BUSY SHALL return to IDLE the cycle after a B handshake (bvalid&bready).
REQ-017 The non-owner, and both masters while the channel is IDLE, SHALL see arready/rvalid (read) or awready/wready/bvalid (write) = 0. Their data fields SHALL be 0.
REQ-018 In IDLE, the channel's downstream fields in axi_req SHALL be 0, including arvalid/rready or awvalid/wvalid/bready.
REQ-019 Each FSM SHALL hold at most one outstanding burst. A grant SHALL NOT change mid-burst regardless of the other master's requests.
REQ-020 Read and write channels SHALL operate concurrently. m0 may own read while m1 owns write, and vice versa.
REQ-021 Default arbitration (both valid in IDLE): m1 SHALL win (fixed priority data over instruction), independently per channel.
REQ-022 A master deasserting valid before its handshake is an AXI violation; the behaviour is unspecified and SHALL NOT be checked.

Reset
REQ-023 While rst=1, both FSMs SHALL go to IDLE and owners to 0 on the next edge, and rd_owner/wr_owner SHALL read 2'b00 after that edge.
REQ-024 Reset mid-burst SHALL abandon the burst without draining. The downstream slave is reset by the same rst.
REQ-025 After reset, every output valid/ready SHALL be 0 until a new grant.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN defined: each channel SHALL keep a last-winner bit (reset 1=m1) and, on conflict, grant the master that is not last-winner. The bit SHALL update on each grant.
REQ-027 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority per REQ-021, with no last-winner state.

Verification
REQ-028 m0 arvalid, araddr=0x1FC00000, arlen=3, alone: owner m0 from cycle 1; axi_req.araddr=0x1FC00000; 4 beats to m0 only; IDLE the cycle after rlast; rd_owner=2'b00.
REQ-029 m0 and m1 arvalid in the same cycle: without the macro, m1 wins twice in a row (m1 re-requests). With the macro, order is m0 (last=m1 at reset), then m1.
REQ-030 m1 write awaddr=0x80001000, wdata=0xDEADBEEF, wstrb=0xF, concurrent with an m0 read burst: both complete. m1 sees bvalid once, and m0 sees rvalid only for its own beats.
REQ-031 m1 arvalid while m0 is mid-burst (beat 2 of 4): m1 arready=0 until the cycle after m0's rlast handshake plus one grant cycle.
REQ-032 rst=1 during beat 2 of an m1 read: next cycle rd_owner=2'b00 and all valids/readies=0. A fresh m0 read afterward completes normally.
